// File: rtl/wb_exc_if.sv
// Write-back commit bus between the pipeline WB stage and the exception unit.
// The pipeline (master) presents the committing instruction; the unit answers with wb_ex and the flush redirect.
interface wb_exc_if #(
    parameter int NUM_EX = 5
);
    logic              wb_valid;
    logic [31:0]       wb_pc;
    logic [NUM_EX-1:0] wb_ex_vec;
    logic [31:0]       wb_vaddr;
    logic              wb_is_ertn;
    logic [31:0]       eentry;
    logic              wb_ex;
    logic              flush;
    logic [31:0]       flush_target;

    modport master (
        output wb_valid, wb_pc, wb_ex_vec, wb_vaddr, wb_is_ertn, eentry,
        input  wb_ex, flush, flush_target
    );

    modport slave (
        input  wb_valid, wb_pc, wb_ex_vec, wb_vaddr, wb_is_ertn, eentry,
        output wb_ex, flush, flush_target
    );
endinterface

// File: rtl/wb_exc_unit.sv
// WB-stage exception/interrupt commit unit: prioritises interrupt, synchronous exceptions and ertn,
// holds ERA/ECODE/BADV/IE/PIE, a countdown timer and synchronised hardware interrupt lines.
module wb_exc_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

module wb_exc_unit #(
    parameter int                     NUM_EX   = 5,
    parameter logic [6*NUM_EX-1:0]    EX_ECODE = {6'h0D, 6'h0C, 6'h0B, 6'h09, 6'h08},
    parameter logic [NUM_EX-1:0]      EX_BADV  = 5'b00011,
    parameter int                     NUM_HWI  = 8,
    parameter int                     TIMER_W  = 32
) (
    input  logic               clk,
    input  logic               resetn,
    wb_exc_if.slave            wb,
    input  logic [NUM_HWI:0]   lie,
    input  logic [NUM_HWI-1:0] hw_int,
    input  logic               csr_ie_we,
    input  logic               csr_ie_wdata,
    input  logic               timer_load,
    input  logic [TIMER_W-1:0] timer_val,
    input  logic               timer_periodic,
    input  logic               timer_en,
    input  logic               ti_clr,
    output logic [31:0]        era,
    output logic [31:0]        badv,
    output logic [5:0]         ecode,
    output logic               ie,
    output logic               pie,
    output logic               ti_pending,
    output logic [NUM_HWI-1:0] hwi_sync
);
    typedef struct packed {
        logic       take;
        logic       ertn;
        logic       badv_we;
        logic [5:0] code;
    } commit_t;

    logic               flush_q;
    logic [31:0]        target_q;
    logic               commit_ok;
    logic               int_req;
    logic [5:0]         ex_code;
    logic               ex_badv;
    commit_t            cm;
    logic [TIMER_W-1:0] cnt;
    logic [TIMER_W-1:0] reload;
    logic [TIMER_W-1:0] cnt_nxt;
    logic               ti_set;

    generate
        for (genvar g = 0; g < NUM_HWI; g++) begin : g_sync
            wb_exc_sync2 u_sync (
                .clk    (clk),
                .resetn (resetn),
                .d      (hw_int[g]),
                .q      (hwi_sync[g])
            );
        end
    endgenerate

    // The flush cycle carries the shadow of the redirected instruction, so it never commits.
    assign commit_ok = wb.wb_valid & ~flush_q;
    assign int_req   = ie & |({ti_pending, hwi_sync} & lie);

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        ex_code = 6'd0;
        ex_badv = 1'b0;
        for (int i = NUM_EX - 1; i >= 0; i--) begin
            if (wb.wb_ex_vec[i]) begin
                ex_code = EX_ECODE[6*i +: 6];
                ex_badv = EX_BADV[i];
            end
        end
    end

    always_comb begin
        cm         = '0;
        cm.take    = commit_ok & (int_req | (|wb.wb_ex_vec));
        cm.ertn    = commit_ok & wb.wb_is_ertn & ~cm.take;
        cm.code    = int_req ? 6'd0 : ex_code;
        cm.badv_we = ~int_req & ex_badv;
    end

    assign wb.wb_ex        = cm.take;
    assign wb.flush        = flush_q;
    assign wb.flush_target = target_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            flush_q  <= 1'b0;
            target_q <= 32'h0;
            era      <= 32'h0;
            badv     <= 32'h0;
            ecode    <= 6'h0;
            ie       <= 1'b0;
            pie      <= 1'b0;
        end else begin
            flush_q <= cm.take | cm.ertn;
            if (cm.take) begin
                target_q <= wb.eentry;
                era      <= wb.wb_pc;
                ecode    <= cm.code;
                if (cm.badv_we)
                    badv <= wb.wb_vaddr;
                pie <= ie;
                ie  <= 1'b0;
            end else if (cm.ertn) begin
                target_q <= era;
                ie       <= pie;
            end else if (csr_ie_we) begin
                ie <= csr_ie_wdata;
            end
        end
    end

    // A load always wins; ti only fires on a real 1->0 decrement, so loading 0 stays silent.
    always_comb begin
        cnt_nxt = cnt;
        ti_set  = 1'b0;
        if (timer_load) begin
            cnt_nxt = timer_val;
        end else if (timer_en && cnt != '0) begin
            if (cnt == TIMER_W'(1)) begin
                ti_set  = 1'b1;
                cnt_nxt = timer_periodic ? reload : '0;
            end else begin
                cnt_nxt = cnt - TIMER_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            reload     <= '0;
            ti_pending <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (timer_load)
                reload <= timer_val;
            ti_pending <= ti_set | (ti_pending & ~ti_clr);
        end
    end
endmodule

// File: tb/tb_wb_exc_unit.sv
// Bench for wb_exc_unit: directed scenarios plus randomized traffic checked against a cycle model.
module tb_wb_exc_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [8:0]  lie;
    logic [7:0]  hw_int;
    logic        csr_ie_we, csr_ie_wdata, timer_load, timer_periodic, timer_en, ti_clr;
    logic [31:0] timer_val;
    logic [31:0] era, badv, era7, badv7;
    logic [5:0]  ecode, ecode7;
    logic        ie, pie, ti_pending, ie7, pie7, ti7;
    logic [7:0]  hwi_sync, hwi7;

    wb_exc_if #(.NUM_EX(5)) bus();
    wb_exc_if #(.NUM_EX(7)) bus7();

    wb_exc_unit dut (
        .clk(clk), .resetn(resetn), .wb(bus.slave), .lie(lie), .hw_int(hw_int),
        .csr_ie_we(csr_ie_we), .csr_ie_wdata(csr_ie_wdata), .timer_load(timer_load),
        .timer_val(timer_val), .timer_periodic(timer_periodic), .timer_en(timer_en),
        .ti_clr(ti_clr), .era(era), .badv(badv), .ecode(ecode), .ie(ie), .pie(pie),
        .ti_pending(ti_pending), .hwi_sync(hwi_sync)
    );

    wb_exc_unit #(
        .NUM_EX(7),
        .EX_ECODE({6'h11, 6'h10, 6'h0D, 6'h0C, 6'h0B, 6'h09, 6'h08}),
        .EX_BADV(7'b1000011)
    ) dut7 (
        .clk(clk), .resetn(resetn), .wb(bus7.slave), .lie(9'h0), .hw_int(8'h0),
        .csr_ie_we(1'b0), .csr_ie_wdata(1'b0), .timer_load(1'b0),
        .timer_val(32'h0), .timer_periodic(1'b0), .timer_en(1'b0),
        .ti_clr(1'b0), .era(era7), .badv(badv7), .ecode(ecode7), .ie(ie7), .pie(pie7),
        .ti_pending(ti7), .hwi_sync(hwi7)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state plus the timer as a plain integer countdown.
    bit          m_flush, m_ie, m_pie, m_ti, last_wb_ex;
    logic [31:0] m_tgt, m_era, m_badv;
    logic [5:0]  m_ecode;
    int unsigned m_cnt, m_reload;
    logic [7:0]  m_s1, m_hwi;
    logic [5:0]  ecode_tab [5] = '{6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D};
    bit          badv_tab  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    function automatic bit m_int();
        return m_ie && (({m_ti, m_hwi} & lie) != 9'h0);
    endfunction

    function automatic bit m_take();
        return bus.wb_valid && !m_flush && (m_int() || bus.wb_ex_vec != 5'h0);
    endfunction

    task automatic model_reset();
        m_flush = 0; m_ie = 0; m_pie = 0; m_ti = 0;
        m_tgt = 0; m_era = 0; m_badv = 0; m_ecode = 0;
        m_cnt = 0; m_reload = 0; m_s1 = 0; m_hwi = 0;
    endtask

    task automatic model_step();
        bit take, ertn, intr, fire;
        int first;
        if (!resetn) begin
            model_reset();
        end else begin
            intr = m_int();
            take = m_take();
            ertn = bus.wb_valid && !m_flush && bus.wb_is_ertn && !take;
            if (take) begin
                first = 0;
                for (int i = 0; i < 5; i++)
                    if (bus.wb_ex_vec[i]) begin first = i; break; end
                m_tgt = bus.eentry;
                m_era = bus.wb_pc;
                if (intr) m_ecode = 6'h0;
                else begin
                    m_ecode = ecode_tab[first];
                    if (badv_tab[first]) m_badv = bus.wb_vaddr;
                end
                m_pie = m_ie;
                m_ie  = 0;
            end else if (ertn) begin
                m_tgt = m_era;
                m_ie  = m_pie;
            end else if (csr_ie_we) begin
                m_ie = csr_ie_wdata;
            end
            m_flush = take || ertn;
            fire = 0;
            if (timer_load) begin
                m_cnt = timer_val; m_reload = timer_val;
            end else if (timer_en && m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    fire = 1;
                    if (timer_periodic) m_cnt = m_reload;
                end
            end
            m_ti  = fire ? 1'b1 : (ti_clr ? 1'b0 : m_ti);
            m_hwi = m_s1;
            m_s1  = hw_int;
        end
    endtask

    task automatic check_regs();
        chk("flush",        64'(bus.flush),        64'(m_flush));
        chk("flush_target", 64'(bus.flush_target), 64'(m_tgt));
        chk("era",          64'(era),              64'(m_era));
        chk("badv",         64'(badv),             64'(m_badv));
        chk("ecode",        64'(ecode),            64'(m_ecode));
        chk("ie",           64'(ie),               64'(m_ie));
        chk("pie",          64'(pie),              64'(m_pie));
        chk("ti_pending",   64'(ti_pending),       64'(m_ti));
        chk("hwi_sync",     64'(hwi_sync),         64'(m_hwi));
    endtask

    // Inputs are set at the negedge; wb_ex is checked before the edge, registers after it.
    task automatic cycle();
        #1;
        last_wb_ex = bus.wb_ex;
        chk("wb_ex", 64'(bus.wb_ex), 64'(m_take()));
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    initial begin
        resetn = 0; lie = 0; hw_int = 0; csr_ie_we = 0; csr_ie_wdata = 0;
        timer_load = 0; timer_val = 0; timer_periodic = 0; timer_en = 0; ti_clr = 0;
        bus.wb_valid = 0; bus.wb_pc = 0; bus.wb_ex_vec = 0; bus.wb_vaddr = 0;
        bus.wb_is_ertn = 0; bus.eentry = 0;
        bus7.wb_valid = 0; bus7.wb_pc = 0; bus7.wb_ex_vec = 0; bus7.wb_vaddr = 0;
        bus7.wb_is_ertn = 0; bus7.eentry = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_regs();
        resetn = 1;

        // SYS
        bus.eentry = 32'h1C008000; bus.wb_pc = 32'h1C000100; bus.wb_vaddr = 32'hDEADBEEF;
        bus.wb_valid = 1; bus.wb_ex_vec = 5'b00100;
        cycle();
        chk("sys_wb_ex",  64'(last_wb_ex),       64'(1));
        chk("sys_flush",  64'(bus.flush),        64'(1));
        chk("sys_target", 64'(bus.flush_target), 64'(32'h1C008000));
        chk("sys_era",    64'(era),              64'(32'h1C000100));
        chk("sys_ecode",  64'(ecode),            64'(6'h0B));
        chk("sys_badv",   64'(badv),             64'(0));

        // INE in the flush shadow must be ignored
        bus.wb_ex_vec = 5'b10000; bus.wb_pc = 32'h1C000104;
        cycle();
        chk("shadow_wb_ex", 64'(last_wb_ex), 64'(0));
        chk("shadow_flush", 64'(bus.flush),  64'(0));
        chk("shadow_era",   64'(era),        64'(32'h1C000100));
        chk("shadow_ecode", 64'(ecode),      64'(6'h0B));

        // ADEF + BRK
        bus.wb_ex_vec = 5'b01001; bus.wb_vaddr = 32'h3; bus.wb_pc = 32'h1C000200;
        cycle();
        chk("adef_ecode", 64'(ecode), 64'(6'h08));
        chk("adef_badv",  64'(badv),  64'(32'h3));

        // Hardware interrupt through the synchronizer
        bus.wb_valid = 0; bus.wb_ex_vec = 0; csr_ie_we = 1; csr_ie_wdata = 1;
        cycle();
        chk("ie_set", 64'(ie), 64'(1));
        csr_ie_we = 0; lie = 9'h001; hw_int = 8'h01; bus.wb_valid = 1; bus.wb_pc = 32'h1C000300;
        cycle();
        chk("hwi_e1_wb_ex", 64'(last_wb_ex), 64'(0));
        chk("hwi_e1_sync",  64'(hwi_sync),   64'(0));
        cycle();
        chk("hwi_e2_wb_ex", 64'(last_wb_ex), 64'(0));
        chk("hwi_e2_sync",  64'(hwi_sync),   64'(1));
        bus.wb_pc = 32'h1C000308;
        cycle();
        chk("int_wb_ex", 64'(last_wb_ex), 64'(1));
        chk("int_ecode", 64'(ecode),      64'(0));
        chk("int_ie",    64'(ie),         64'(0));
        chk("int_pie",   64'(pie),        64'(1));
        chk("int_era",   64'(era),        64'(32'h1C000308));
        chk("int_badv",  64'(badv),       64'(32'h3));
        hw_int = 0; bus.wb_valid = 0;
        cycle();
        bus.wb_valid = 1; bus.wb_is_ertn = 1; bus.wb_pc = 32'h1C000400;
        cycle();
        chk("ertn_wb_ex",  64'(last_wb_ex),       64'(0));
        chk("ertn_flush",  64'(bus.flush),        64'(1));
        chk("ertn_target", 64'(bus.flush_target), 64'(32'h1C000308));
        chk("ertn_ie",     64'(ie),               64'(1));
        lie = 0; bus.wb_valid = 0; bus.wb_is_ertn = 0;
        cycle();

        // ertn + ALE with a competing IE write
        bus.wb_valid = 1; bus.wb_is_ertn = 1; bus.wb_ex_vec = 5'b00010; bus.wb_vaddr = 32'h55;
        bus.wb_pc = 32'h1C000500; csr_ie_we = 1; csr_ie_wdata = 1;
        cycle();
        chk("ale_ecode",  64'(ecode),            64'(6'h09));
        chk("ale_ie",     64'(ie),               64'(0));
        chk("ale_pie",    64'(pie),              64'(1));
        chk("ale_target", 64'(bus.flush_target), 64'(32'h1C008000));
        chk("ale_badv",   64'(badv),             64'(32'h55));
        bus.wb_valid = 0; bus.wb_is_ertn = 0; bus.wb_ex_vec = 0; csr_ie_we = 0;

        // Timer one-shot
        timer_en = 1; timer_load = 1; timer_val = 3; timer_periodic = 0;
        cycle();
        timer_load = 0;
        cycle(); chk("os_l1", 64'(ti_pending), 64'(0));
        cycle(); chk("os_l2", 64'(ti_pending), 64'(0));
        cycle(); chk("os_l3", 64'(ti_pending), 64'(1));
        repeat (3) cycle();
        chk("os_hold", 64'(ti_pending), 64'(1));
        ti_clr = 1; cycle(); ti_clr = 0;
        chk("os_clr", 64'(ti_pending), 64'(0));
        repeat (4) cycle();
        chk("os_stopped", 64'(ti_pending), 64'(0));

        // Timer periodic
        timer_load = 1; timer_periodic = 1;
        cycle();
        timer_load = 0;
        repeat (3) cycle();
        chk("per_l3", 64'(ti_pending), 64'(1));
        ti_clr = 1; cycle(); ti_clr = 0;
        chk("per_l4", 64'(ti_pending), 64'(0));
        cycle();
        chk("per_l5", 64'(ti_pending), 64'(0));
        ti_clr = 1; cycle(); ti_clr = 0;
        chk("per_set_wins", 64'(ti_pending), 64'(1));

        // Loading zero never raises ti
        ti_clr = 1; timer_load = 1; timer_val = 0;
        cycle();
        ti_clr = 0; timer_load = 0;
        chk("load0_clr", 64'(ti_pending), 64'(0));
        repeat (4) cycle();
        chk("load0_quiet", 64'(ti_pending), 64'(0));

        // Reset during the flush cycle
        bus.wb_valid = 1; bus.wb_ex_vec = 5'b00001; bus.wb_pc = 32'h1C000600; bus.wb_vaddr = 32'h77;
        cycle();
        chk("pre_rst_flush", 64'(bus.flush), 64'(1));
        resetn = 0;
        #1;
        chk("rst_flush",  64'(bus.flush),        64'(0));
        chk("rst_target", 64'(bus.flush_target), 64'(0));
        chk("rst_era",    64'(era),              64'(0));
        chk("rst_badv",   64'(badv),             64'(0));
        chk("rst_ecode",  64'(ecode),            64'(0));
        chk("rst_pie",    64'(pie),              64'(0));
        model_reset();
        cycle();
        bus.wb_valid = 0; bus.wb_ex_vec = 0; resetn = 1;
        cycle();

        // Seven-source table
        bus7.eentry = 32'h1C009000; bus7.wb_valid = 1; bus7.wb_pc = 32'h1C000700;
        bus7.wb_vaddr = 32'hABC; bus7.wb_ex_vec = 7'b1000000;
        #1;
        chk("ex7_wb_ex", 64'(bus7.wb_ex), 64'(1));
        cycle();
        chk("ex7_ecode", 64'(ecode7),    64'(6'h11));
        chk("ex7_badv",  64'(badv7),     64'(32'hABC));
        chk("ex7_flush", 64'(bus7.flush), 64'(1));
        bus7.wb_valid = 0;
        cycle();
        bus7.wb_valid = 1; bus7.wb_ex_vec = 7'b1010000; bus7.wb_vaddr = 32'hDEF;
        cycle();
        chk("ex7_prio_ecode", 64'(ecode7), 64'(6'h0D));
        chk("ex7_prio_badv",  64'(badv7),  64'(32'hABC));
        bus7.wb_valid = 0;

        // Random traffic
        repeat (600) begin
            bus.wb_valid   = $urandom_range(0, 3) != 0;
            bus.wb_pc      = $urandom;
            bus.wb_vaddr   = $urandom;
            bus.eentry     = $urandom;
            bus.wb_ex_vec  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h0;
            bus.wb_is_ertn = $urandom_range(0, 5) == 0;
            lie            = 9'($urandom);
            if ($urandom_range(0, 7) == 0) hw_int = 8'($urandom);
            csr_ie_we      = $urandom_range(0, 4) == 0;
            csr_ie_wdata   = 1'($urandom_range(0, 1));
            timer_load     = $urandom_range(0, 15) == 0;
            timer_val      = $urandom_range(0, 5);
            timer_periodic = 1'($urandom_range(0, 1));
            timer_en       = $urandom_range(0, 7) != 0;
            ti_clr         = $urandom_range(0, 9) == 0;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
